// File: rtl/seg7_pkg.sv
// Shared constants and glyph table for the 7-segment display blocks.
// Glyphs are active-low {g,f,e,d,c,b,a}; the decimal point is handled separately.
package seg7_pkg;

    localparam int NUM_DIGITS = 6;

    localparam logic [6:0] GLYPH_0     = 7'h40;
    localparam logic [6:0] GLYPH_1     = 7'h79;
    localparam logic [6:0] GLYPH_2     = 7'h24;
    localparam logic [6:0] GLYPH_3     = 7'h30;
    localparam logic [6:0] GLYPH_4     = 7'h19;
    localparam logic [6:0] GLYPH_5     = 7'h12;
    localparam logic [6:0] GLYPH_6     = 7'h02;
    localparam logic [6:0] GLYPH_7     = 7'h78;
    localparam logic [6:0] GLYPH_8     = 7'h00;
    localparam logic [6:0] GLYPH_9     = 7'h10;
    localparam logic [6:0] GLYPH_DASH  = 7'h3F;
    localparam logic [6:0] GLYPH_BLANK = 7'h7F;

    // Non-decimal nibbles show a dash so corrupted BCD is visible on the display.
    function automatic logic [6:0] nibble_to_glyph(input logic [3:0] nibble);
        logic [6:0] glyph;
        case (nibble)
            4'd0:    glyph = GLYPH_0;
            4'd1:    glyph = GLYPH_1;
            4'd2:    glyph = GLYPH_2;
            4'd3:    glyph = GLYPH_3;
            4'd4:    glyph = GLYPH_4;
            4'd5:    glyph = GLYPH_5;
            4'd6:    glyph = GLYPH_6;
            4'd7:    glyph = GLYPH_7;
            4'd8:    glyph = GLYPH_8;
            4'd9:    glyph = GLYPH_9;
            default: glyph = GLYPH_DASH;
        endcase
        return glyph;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble-to-segment decoder producing an active-low {dp,g..a} pattern.
// Usable standalone for static HEX displays as well as inside the scan driver.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    input  logic       dp,
    output logic [7:0] seg
);

    // The decimal point stays lit even on a blanked digit.
    assign seg = {~dp, blank ? GLYPH_BLANK : nibble_to_glyph(nibble)};

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 6-digit common-anode display driver with per-frame snapshot,
// leading-zero blanking and a blank interval at the start of every digit slot.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIGIT_TICKS = 50_000,
    parameter int BLANK_TICKS = 500
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*NUM_DIGITS-1:0] data,
    input  logic [NUM_DIGITS-1:0] dp_mask,
    input  logic                  blank_en,
    output logic [NUM_DIGITS-1:0] sel,
    output logic [7:0]            seg,
    output logic                  frame_start
);

    localparam int CW = $clog2(DIGIT_TICKS);
    localparam logic [CW-1:0] TICK_LAST  = CW'(DIGIT_TICKS - 1);
    localparam logic [CW-1:0] BLANK_END  = CW'(BLANK_TICKS);
    localparam logic [2:0]    DIGIT_LAST = 3'(NUM_DIGITS - 1);

    logic [CW-1:0]             tick_cnt;
    logic [2:0]                digit_idx;
    logic [4*NUM_DIGITS-1:0]   shadow_data;
    logic [NUM_DIGITS-1:0]     shadow_dp;
    logic                      tick_wrap;
    logic                      snapshot;
    logic [NUM_DIGITS-1:0]     lead_zero;
    logic [3:0]                cur_nibble;
    logic                      cur_blank;
    logic                      cur_dp;
    logic [7:0]                seg_next;

    assign tick_wrap = (tick_cnt == TICK_LAST);
    assign snapshot  = tick_wrap && (digit_idx == DIGIT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt  <= '0;
            digit_idx <= '0;
        end else if (tick_wrap) begin
            tick_cnt  <= '0;
            digit_idx <= (digit_idx == DIGIT_LAST) ? 3'd0 : digit_idx + 3'd1;
        end else begin
            tick_cnt  <= tick_cnt + 1'b1;
        end
    end

    // Loading only at the very end of slot 5 keeps a whole frame on one value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_data <= '0;
            shadow_dp   <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= snapshot;
            if (snapshot) begin
                shadow_data <= data;
                shadow_dp   <= dp_mask;
            end
        end
    end

    // lead_zero[i]: every shadow digit from i up to the most significant is zero.
    always_comb begin
        lead_zero = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            lead_zero[i] = ((shadow_data >> (4 * i)) == '0);
        end
    end

    assign cur_nibble = shadow_data[{digit_idx, 2'b00} +: 4];
    assign cur_dp     = shadow_dp[digit_idx];
    assign cur_blank  = blank_en && (digit_idx != 3'd0) && lead_zero[digit_idx];

    seg7_decode u_decode (
        .nibble (cur_nibble),
        .blank  (cur_blank),
        .dp     (cur_dp),
        .seg    (seg_next)
    );

    // Turning all selects off early in each slot hides ghosting between digits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel <= '1;
            seg <= 8'hFF;
        end else if (tick_cnt < BLANK_END) begin
            sel <= '1;
            seg <= 8'hFF;
        end else begin
            sel <= ~(NUM_DIGITS'(1) << digit_idx);
            seg <= seg_next;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: a frame-level reference model predicts
// every output cycle, and a separate monitor compares the DUT against the queue.
module tb_seg7_scan_driver;

    localparam int DT    = 10;
    localparam int BT    = 2;
    localparam int FRAME = 6 * DT;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [23:0] data = '0;
    logic [5:0]  dp_mask = '0;
    logic        blank_en = 1'b0;
    logic [5:0]  sel;
    logic [7:0]  seg;
    logic        frame_start;

    typedef struct packed {
        logic [5:0] sel;
        logic [7:0] seg;
        logic       fs;
    } exp_t;

    exp_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;
    int          t = 0;
    logic [23:0] sh_data = '0;
    logic [5:0]  sh_mask = '0;
    logic [7:0]  glyph_tab [16];

    seg7_scan_driver #(.DIGIT_TICKS(DT), .BLANK_TICKS(BT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .data        (data),
        .dp_mask     (dp_mask),
        .blank_en    (blank_en),
        .sel         (sel),
        .seg         (seg),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    // Expected display for frame position q (outputs lag the scan position by one cycle).
    function automatic exp_t model(input int q);
        exp_t e;
        int   slot;
        int   cyc;
        bit   all_zero;
        slot = (q / DT) % 6;
        cyc  = q % DT;
        e.fs = ((t % FRAME) == 0);
        if (cyc < BT) begin
            e.sel = 6'h3F;
            e.seg = 8'hFF;
        end else begin
            e.sel = 6'h3F;
            e.sel[slot] = 1'b0;
            all_zero = 1'b1;
            for (int d = slot; d < 6; d++)
                if (sh_data[4*d +: 4] != 4'd0) all_zero = 1'b0;
            if (blank_en && slot != 0 && all_zero) e.seg = 8'hFF;
            else                                   e.seg = glyph_tab[sh_data[4*slot +: 4]];
            if (sh_mask[slot]) e.seg[7] = 1'b0;
        end
        return e;
    endfunction

    task automatic apply_stimulus(input bit reset_mid);
        exp_t e;
        @(posedge clk);
        if (!rst_n || reset_mid) begin
            t       = 0;
            sh_data = '0;
            sh_mask = '0;
            e.sel = 6'h3F;
            e.seg = 8'hFF;
            e.fs  = 1'b0;
            exp_q.push_back(e);
        end else begin
            t++;
            exp_q.push_back(model(t - 1));
            if ((t % FRAME) == 0) begin
                sh_data = data;
                sh_mask = dp_mask;
            end
        end
        #1;
        if (reset_mid) rst_n = 1'b0;
    endtask

    task automatic check_output(input exp_t e);
        checks++;
        if (sel !== e.sel) begin
            errors++;
            $display("[TB] FAIL sel t=%0d actual=%h required=%h", t, sel, e.sel);
        end
        checks++;
        if (seg !== e.seg) begin
            errors++;
            $display("[TB] FAIL seg t=%0d actual=%h required=%h", t, seg, e.seg);
        end
        checks++;
        if (frame_start !== e.fs) begin
            errors++;
            $display("[TB] FAIL frame_start t=%0d actual=%b required=%b", t, frame_start, e.fs);
        end
    endtask

    task automatic run(input int n);
        repeat (n) apply_stimulus(1'b0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_output(e);
            end
        end
    end

    initial begin : stimulus
        logic [23:0] rnd;
        int          lz;
        glyph_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                      8'h80, 8'h90, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF};

        // Reset held, then first frame must show the cleared shadow.
        run(5);
        rst_n = 1'b1;
        data  = 24'h123456;
        run(2 * FRAME);

        blank_en = 1'b1;
        data     = 24'h000042;
        run(2 * FRAME);
        data = 24'h000000;
        run(2 * FRAME);

        // Mid-frame change must wait for the next snapshot.
        data = 24'h111111;
        run(FRAME);
        run(25);
        data = 24'h222222;
        run(2 * FRAME - 25);

        blank_en = 1'b0;
        data     = 24'h0000A0;
        dp_mask  = 6'b000100;
        run(2 * FRAME);

        repeat (8 * FRAME) begin
            if ($urandom_range(0, 29) == 0) begin
                rnd = 24'($urandom);
                lz  = $urandom_range(0, 6);
                for (int i = 0; i < 6; i++)
                    if (i >= 6 - lz) rnd[4*i +: 4] = 4'd0;
                data     = rnd;
                dp_mask  = 6'($urandom);
                blank_en = 1'($urandom);
            end
            apply_stimulus(1'b0);
        end

        // Asynchronous reset while the scan sits at slot 3, cycle 5.
        while ((t % FRAME) != 34) apply_stimulus(1'b0);
        apply_stimulus(1'b1);
        data     = 24'h999999;
        dp_mask  = 6'h3F;
        blank_en = 1'b1;
        run(3);
        rst_n = 1'b1;
        run(2 * FRAME);

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Downstream consumer of the 6-digit packed-BCD counter value (24 bits, digit 0 = bits [3:0]).
- Drives a time-multiplexed 6-digit common-anode 7-segment display: one digit select at a time, registered segment pattern.
- Applies per-digit decimal points, optional leading-zero blanking and inter-digit ghost blanking.
- Snapshots its input once per frame, so a display frame never mixes two counter values.

Parameters:
- DIGIT_TICKS, 50_000: clk cycles per digit slot (1 ms at 50 MHz); legal range 4 to 2^20-1.
- BLANK_TICKS, 500: cycles at the start of each slot with all selects off; must be < DIGIT_TICKS.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset: asynchronous, active-low.
- data  in  24  packed BCD value, digit i = data[4i+3:4i].
- dp_mask  in  6  bit i = 1 lights the decimal point of digit i.
- blank_en  in  1  1 = enable leading-zero blanking.
- sel  out  6  digit selects, active-low; sel[i] = 0 enables digit i.
- seg  out  8  {dp,g,f,e,d,c,b,a}, active-low.
- frame_start  out  1  one-clk pulse when a new snapshot is taken.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-slot):
  - tick counter c = 0, digit index k = 0.
  - shadow data = 0, shadow dp_mask = 0.
  - sel = 6'h3F, seg = 8'hFF, frame_start = 0.
- Tick counter: c counts 0..DIGIT_TICKS-1 and wraps to 0. On wrap, k advances 0→1→…→5→0.
- Snapshot:
  - Occurs on the cycle where c == DIGIT_TICKS-1 and k == 5; data and dp_mask load into shadow registers.
  - frame_start is registered and is high for exactly the one cycle after the load, i.e. the first cycle of slot 0.
  - The first frame after reset displays shadow = 0.
- Outputs are registered, one cycle after (k, c):
  - If c < BLANK_TICKS: sel = 6'h3F and seg = 8'hFF.
  - Otherwise: sel = ~(6'b1 << k) and seg = glyph of shadow digit k.
- Glyph encoding, seg[6:0] active-low, dp bit separate:
  - Digits 0–9: C0, F9, A4, B0, 99, 92, 82, F8, 80, 90 (with dp off).
  - Nibble A–F: dash BF.
  - Blanked digit: FF.
  - dp_mask[k] = 1 clears seg[7], including on blanked digits.
- Leading-zero blanking, when blank_en = 1:
  - Digit i (i = 5..1) is blanked iff shadow digits i..5 are all zero.
  - Digit 0 is never blanked.
  - blank_en is sampled live, not snapshotted.
- Slot k ends after exactly DIGIT_TICKS cycles; a full frame is 6·DIGIT_TICKS cycles.
- Changes to data mid-frame have no effect until the next snapshot; worst-case latency is 6·DIGIT_TICKS+1 cycles.

Decomposition:
- Package seg7_pkg holds:
  - NUM_DIGITS = 6.
  - Glyph constants: GLYPH_0..GLYPH_9, GLYPH_DASH = 7'h3F, GLYPH_BLANK = 7'h7F.
  - A nibble-to-glyph function.
- One sub-module, seg7_decode: combinational nibble + blank + dp → 8-bit active-low pattern. Also reusable for static HEX outputs.
- The scan counter, snapshot and select logic stay in seg7_scan_driver.

Test Plan:
All scenarios use DIGIT_TICKS = 10 and BLANK_TICKS = 2.
1. Hold rst_n = 0 for 5 cycles, release → sel = 3F and seg = FF during reset. First frame shows digit 0 = C0 (blank_en = 0), and frame_start pulses at the start of the second frame.
2. data = 24'h123456, blank_en = 0, dp_mask = 0, second frame:
   - Slot 0 cycles 0–1: sel = 3F; cycles 2–9: sel = 3E, seg = 82.
   - Slot 5: sel = 1F, seg = F9.
3. blank_en = 1:
   - data = 24'h000042 → digits 5..2 seg = FF, digit 1 = 99, digit 0 = A4.
   - data = 0 → only digit 0 shows C0.
4. data = 24'h111111; switch to 24'h222222 during slot 2 → slots 3–5 still F9. The next frame shows A4 on all digits, with frame_start high for exactly one cycle.
5. data = 24'h0000A0, dp_mask = 6'b000100, blank_en = 0 → digit 1 seg = BF, digit 2 seg = 40 (0 with dp), digit 0 seg = C0.
6. Assert rst_n low at slot 3 cycle 5 → sel = 3F and seg = FF within the same cycle (asynchronous). After release, scanning restarts at slot 0 cycle 0 with shadow = 0.
